// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit per slot, blanking gap at slot start,
// double-buffered display value swapped only at frame boundaries, optional leading-zero blanking.
module fnd_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lzb_en,
  output logic [3:0]            number,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   staged_q, staged_d;
  logic                  pending_q, pending_d;
  logic [3:0]            number_q, number_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end, wrap, boundary, zero_above, cur_blank;
  logic [DIGITS-1:0]     lz_blank;

  always_comb begin
    slot_end = (cnt_q == CW'(DIV - 1));
    wrap     = (idx_q == IW'(DIGITS - 1));
    boundary = slot_end && wrap;

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + IW'(1);

    staged_d  = load ? value : staged_q;
    pending_d = pending_q | load;
    shadow_d  = shadow_q;
    // A load in the boundary cycle bypasses staging so it lands in the very next frame.
    if (boundary) begin
      if (load)           shadow_d = value;
      else if (pending_q) shadow_d = staged_q;
      pending_d = 1'b0;
    end

    // Digit k is a leading zero when it and every more-significant nibble are zero.
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above  = zero_above && (shadow_q[4*k +: 4] == 4'h0);
      lz_blank[k] = (k != 0) && zero_above && lzb_en;
    end

    number_d  = '0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        number_d  = shadow_q[4*k +: 4];
        cur_blank = lz_blank[k];
      end
    end

    digit_en_d = '1;
    if (!(cnt_q < CW'(BLANK)) && !cur_blank) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IW'(k)) digit_en_d[k] = 1'b0;
      end
    end

    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      staged_q     <= '0;
      pending_q    <= 1'b0;
      number_q     <= 4'h0;
      digit_en_q   <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      staged_q     <= staged_d;
      pending_q    <= pending_d;
      number_q     <= number_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign number     = number_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl (DIGITS=4, DIV=8, BLANK=2): stimulus pushes the expected
// registered outputs for each edge; a monitor pops and compares one entry per clock.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        lzb_en = 1'b0;
  logic [3:0]  number;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        pending;

  fnd_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .lzb_en     (lzb_en),
    .number     (number),
    .digit_en   (digit_en),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] num;
    logic [3:0] en;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: cycles since reset release, displayed value, staged value, pending flag.
  int          m_pos = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [15:0] m_staged = 16'h0000;
  logic        m_pend = 1'b0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (number !== e.num || digit_en !== e.en || frame_done !== e.fd || pending !== e.pend) begin
        n_bad++;
        $display("FAIL vec%0d: got num=%h en=%b fd=%b pend=%b, want num=%h en=%b fd=%b pend=%b",
                 n_vec, number, digit_en, frame_done, pending, e.num, e.en, e.fd, e.pend);
      end
    end
  end

  task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic lz);
    exp_t       e;
    int         c, d, msd;
    logic       bnd;
    logic [3:0] one;
    @(negedge clk);
    rst    = r;
    load   = ld;
    value  = v;
    lzb_en = lz;
    one    = 4'b0001;
    if (r) begin
      e.num = 4'h0; e.en = 4'hF; e.fd = 1'b0; e.pend = 1'b0;
      m_pos = 0; m_shadow = 16'h0; m_staged = 16'h0; m_pend = 1'b0;
    end else begin
      c   = m_pos % 8;
      d   = (m_pos / 8) % 4;
      bnd = (c == 7) && (d == 3);
      msd = 0;
      for (int k = 0; k < 4; k++) if (m_shadow[4*k +: 4] != 4'h0) msd = k;
      e.num = m_shadow[4*d +: 4];
      e.en  = (c < 2 || (lz && d > msd)) ? 4'hF : ~(one << d);
      e.fd  = bnd;
      if (ld) begin m_staged = v; m_pend = 1'b1; end
      if (bnd) begin
        if (m_pend) m_shadow = m_staged;
        m_pend = 1'b0;
      end
      e.pend = m_pend;
      m_pos++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'hFFFF, lz);
  endtask

  // Advance until the scan position within the frame equals k (cnt + 8*idx).
  task automatic run_to(input int k, input logic lz);
    while ((m_pos % 32) != k) step(1'b0, 1'b0, 16'hFFFF, lz);
  endtask

  initial begin
    // Reset held three cycles.
    repeat (3) step(1'b1, 1'b0, 16'h0000, 1'b0);
    // Load 1234 one cycle after release; it appears after the first frame boundary.
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(30 + 32, 1'b0);
    // Mid-frame load while 1234 is on display.
    run_to(12, 1'b0);
    step(1'b0, 1'b1, 16'hABCD, 1'b0);
    idle(19 + 32, 1'b0);
    // Leading-zero blanking with 0050, then with 0000.
    run_to(5, 1'b1);
    step(1'b0, 1'b1, 16'h0050, 1'b1);
    run_to(0, 1'b1);
    idle(32, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    run_to(0, 1'b1);
    idle(32, 1'b1);
    idle(32, 1'b0);
    // Load in the exact boundary cycle overrides a staged value.
    run_to(10, 1'b0);
    step(1'b0, 1'b1, 16'h9999, 1'b0);
    run_to(31, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b0);
    idle(32, 1'b0);
    // Reset at cnt=4 of digit 2, then restart from digit 0.
    run_to(20, 1'b0);
    step(1'b1, 1'b0, 16'hFFFF, 1'b0);
    idle(20, 1'b0);
    step(1'b0, 1'b1, 16'h0708, 1'b1);
    idle(40, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
